pixel_fifo: RTL and testbench
=============================

PIXEL_FIFO -- requirements
Module: pixel_fifo

Interface
REQ-001 Parameter DEPTH, default 512, entry count; power of two, at least 4.
REQ-002 Parameter WIDTH, default 16, pixel word width (RGB565 or gray8 in [7:0]).
REQ-003 Parameter LOW_WATER, default 128, refill threshold in entries; range 1..DEPTH-1.
REQ-004 clk_i  input  1  single clock for all logic; pixel clock domain.
REQ-005 rst_ni  input  1  asynchronous, active-low reset.
REQ-006 flush_i  input  1  synchronous clear; pulsed by the frame reader at frame start.
REQ-007 wr_en  input  1  write strobe from the SDRAM read path.
REQ-008 wr_data  input  WIDTH  pixel word to store.
REQ-009 full  output  1  high when level equals DEPTH.
REQ-010 rd_en  input  1  pop strobe from the VGA stage.
REQ-011 rd_data  output  WIDTH  head-of-queue word; show-ahead.
REQ-012 empty  output  1  high when level equals 0.
REQ-013 level  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 refill_req  output  1  high when level is below LOW_WATER.

Function
REQ-015 The block SHALL be a synchronous first-word-fall-through FIFO.
- rd_data SHALL present the oldest stored word whenever empty is low, with no read latency.
- The VGA stage SHALL sample rd_data combinationally in the same cycle it asserts rd_en.
REQ-016 A write accepted in cycle N SHALL be visible in cycle N+1: empty low, level incremented, and rd_data valid if the FIFO was empty.
REQ-017 A pop in cycle N SHALL expose the next word on rd_data in cycle N+1.
REQ-018 wr_en while full SHALL be dropped, even if rd_en is high in the same cycle; no pointer or storage change.
REQ-019 rd_en while empty SHALL be ignored; rd_data is don't-care and pointers are unchanged.
REQ-020 Simultaneous accepted write and pop (not full, not empty) SHALL leave level unchanged and advance both pointers.
REQ-021 Read and write pointers SHALL wrap from DEPTH-1 to 0; level SHALL be tracked explicitly so that full and empty are unambiguous.
REQ-022 flush_i high SHALL clear both pointers and level in the next cycle. It has priority over wr_en and rd_en in the same cycle, which are dropped. Storage contents need not be cleared.
REQ-023 full, empty, level and refill_req SHALL be derived from registered state only, with no combinational path from wr_en or rd_en.
REQ-024 refill_req SHALL equal (level < LOW_WATER), updated in the same cycle as level.

Reset
REQ-025 While rst_ni is low, all outputs SHALL be forced asynchronously: pointers 0, level 0, empty 1, full 0, refill_req 1.
REQ-026 Assertion of rst_ni mid-operation SHALL discard all stored words.
REQ-027 The first write accepted after reset release SHALL be visible on rd_data one cycle later.

Configuration
REQ-028 Macro PIXEL_FIFO_ERR_EN SHALL add four outputs:
- overflow_o, 1 bit, sticky
- underflow_o, 1 bit, sticky
- ovf_cnt_o, 16 bits, saturating
- udf_cnt_o, 16 bits, saturating
REQ-029 With PIXEL_FIFO_ERR_EN defined:
- Each dropped write (REQ-018) SHALL set overflow_o and increment ovf_cnt_o.
- Each ignored read (REQ-019) SHALL set underflow_o and increment udf_cnt_o.
- Counters SHALL saturate at 16'hFFFF.
- All four outputs SHALL be cleared by reset and by flush_i.
REQ-030 Without PIXEL_FIFO_ERR_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then write 16'hF800 in cycle 0 -> cycle 1: empty=0, rd_data=16'hF800, level=1, refill_req=1.
REQ-032 Write 512 words 0..511 with no reads -> full=1, level=512; a further write of 16'hDEAD with rd_en=1 pops 0, drops 16'hDEAD, next rd_data=1, level=511; with PIXEL_FIFO_ERR_EN, ovf_cnt_o=1.
REQ-033 Stream continuous write plus read for 2000 cycles at level 200 -> level holds at 200, data order preserved across pointer wrap, refill_req=0.
REQ-034 Drain from level 128 to 127 -> refill_req rises in the same cycle level reads 127; rd_en on empty -> no state change, underflow_o=1 when enabled.
REQ-035 Level 300, then assert flush_i together with wr_en and rd_en -> next cycle level=0, empty=1, refill_req=1, written word absent.
REQ-036 Drop rst_ni asynchronously mid-stream at level 50 -> outputs take reset values before the next clk_i edge.

Source files
------------

// File: rtl/pixel_fifo.sv
// -----------------------------------------------------------------------------
// pixel_fifo
//   First-word-fall-through FIFO that buffers pixel words between the SDRAM
//   read path (writer) and the VGA output stage (reader). The head word is
//   always on rd_data while the FIFO is not empty, so the reader can sample it
//   in the same cycle it pops. Occupancy is tracked in an explicit level
//   register, which keeps full and empty unambiguous when the pointers are
//   equal.
//
// Parameters
//   DEPTH      entry count, power of two, >= 4
//   WIDTH      pixel word width
//   LOW_WATER  refill threshold in entries, 1..DEPTH-1
//
// Ports
//   clk_i       pixel clock
//   rst_ni      asynchronous active-low reset
//   flush_i     synchronous clear (frame start); overrides wr_en/rd_en
//   wr_en       write strobe, dropped while full
//   wr_data     word to store
//   full        level == DEPTH
//   rd_en       pop strobe, ignored while empty
//   rd_data     head-of-queue word (show-ahead)
//   empty       level == 0
//   level       current occupancy
//   refill_req  level < LOW_WATER
//
// Optional feature (macro PIXEL_FIFO_ERR_EN)
//   overflow_o   sticky flag, set by each dropped write
//   underflow_o  sticky flag, set by each ignored pop
//   ovf_cnt_o    saturating count of dropped writes
//   udf_cnt_o    saturating count of ignored pops
//   All four are cleared by reset and by flush_i.
// -----------------------------------------------------------------------------
module pixel_fifo #(
  parameter int DEPTH     = 512,
  parameter int WIDTH     = 16,
  parameter int LOW_WATER = 128
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     refill_req
`ifdef PIXEL_FIFO_ERR_EN
  ,
  output logic                     overflow_o,
  output logic                     underflow_o,
  output logic [15:0]              ovf_cnt_o,
  output logic [15:0]              udf_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q,  level_d;
  logic             wr_accept;
  logic             rd_accept;

  // Status flags come from the level register only, so there is no
  // combinational path from the strobes to any flag.
  assign full       = (level_q == LW'(DEPTH));
  assign empty      = (level_q == '0);
  assign level      = level_q;
  assign refill_req = (level_q < LW'(LOW_WATER));

  // Show-ahead read: the head word is driven straight from storage.
  assign rd_data = mem_q[rd_ptr_q];

  // Flush wins over both strobes; a write is judged against the current full
  // flag only, so a simultaneous pop cannot make room for it.
  assign wr_accept = wr_en && !full  && !flush_i;
  assign rd_accept = rd_en && !empty && !flush_i;

  // Pointers are AW bits wide, so the +1 wraps from DEPTH-1 to 0 naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_accept) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({wr_accept, rd_accept})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage has no reset; the level register alone decides which
  // entries are valid, and leaving the array reset-free lets it map to RAM.
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef PIXEL_FIFO_ERR_EN
  logic        ovf_event;
  logic        udf_event;
  logic        overflow_q, underflow_q;
  logic [15:0] ovf_cnt_q,  udf_cnt_q;

  // A strobe discarded because of flush is not an error; only the full/empty
  // rejections count.
  assign ovf_event = wr_en && full  && !flush_i;
  assign udf_event = rd_en && empty && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      ovf_cnt_q   <= '0;
      udf_cnt_q   <= '0;
    end else if (flush_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      ovf_cnt_q   <= '0;
      udf_cnt_q   <= '0;
    end else begin
      if (ovf_event) begin
        overflow_q <= 1'b1;
        if (ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
      end
      if (udf_event) begin
        underflow_q <= 1'b1;
        if (udf_cnt_q != 16'hFFFF) udf_cnt_q <= udf_cnt_q + 16'd1;
      end
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
  assign ovf_cnt_o   = ovf_cnt_q;
  assign udf_cnt_o   = udf_cnt_q;
`endif

endmodule

// File: tb/tb_pixel_fifo.sv
// -----------------------------------------------------------------------------
// tb_pixel_fifo
//   Scoreboard bench for pixel_fifo. The stimulus task pushes every word the
//   FIFO should accept into an expected-data queue and keeps an occupancy
//   count from the queue rules; a negedge monitor compares status flags and,
//   on every effective pop, the head word against the queue front.
// -----------------------------------------------------------------------------
module tb_pixel_fifo;

  localparam int DEPTH     = 512;
  localparam int WIDTH     = 16;
  localparam int LOW_WATER = 128;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic [LW-1:0]    level;
  logic             refill;
`ifdef PIXEL_FIFO_ERR_EN
  logic             overflow;
  logic             underflow;
  logic [15:0]      ovf_cnt;
  logic [15:0]      udf_cnt;
`endif

  always #5 clk = ~clk;

  pixel_fifo #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .LOW_WATER (LOW_WATER)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .level      (level),
    .refill_req (refill)
`ifdef PIXEL_FIFO_ERR_EN
    ,
    .overflow_o  (overflow),
    .underflow_o (underflow),
    .ovf_cnt_o   (ovf_cnt),
    .udf_cnt_o   (udf_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the words the FIFO should hold, oldest first, and the
  // occupancy that the DUT state should currently show.
  logic [WIDTH-1:0] exp_q [$];
  int               cnt = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus (called just after a rising edge), push the
  // word the queue rules say is accepted, then advance the model occupancy
  // once the edge has been taken.
  task automatic step(input bit w, input bit r, input bit f,
                      input logic [WIDTH-1:0] d);
    bit wa;
    bit ra;
    wr_en   = w;
    rd_en   = r;
    flush   = f;
    wr_data = d;
    wa = !f && w && (cnt < DEPTH);
    ra = !f && r && (cnt > 0);
    if (wa) exp_q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    if (f) begin
      exp_q.delete();
      cnt = 0;
    end else begin
      cnt = cnt + int'(wa) - int'(ra);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_level"},  32'(level),  32'd0);
    check({tag, "_empty"},  32'(empty),  32'd1);
    check({tag, "_full"},   32'(full),   32'd0);
    check({tag, "_refill"}, 32'(refill), 32'd1);
`ifdef PIXEL_FIFO_ERR_EN
    check({tag, "_overflow"},  32'(overflow),  32'd0);
    check({tag, "_underflow"}, 32'(underflow), 32'd0);
    check({tag, "_ovf_cnt"},   32'(ovf_cnt),   32'd0);
    check({tag, "_udf_cnt"},   32'(udf_cnt),   32'd0);
`endif
  endtask

  // Drop reset between edges while both strobes are active, check outputs
  // before the next edge, then release away from an edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #1;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = WIDTH'($urandom());
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values(tag);
    exp_q.delete();
    cnt = 0;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: status against model occupancy every cycle; head word against
  // the queue front whenever a pop takes effect.
  always @(negedge clk) begin
    if (rst_n) begin
      check("level",      32'(level),  32'(cnt));
      check("empty",      32'(empty),  32'(cnt == 0));
      check("full",       32'(full),   32'(cnt == DEPTH));
      check("refill_req", 32'(refill), 32'(cnt < LOW_WATER));
      if (rd_en && !flush && cnt > 0) begin
        logic [WIDTH-1:0] exp_word;
        exp_word = exp_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(exp_word));
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    #12;
    check_reset_values("por");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First write after reset is visible one cycle later.
    step(1'b1, 1'b0, 1'b0, 16'hF800);
    check("first_rd_data", 32'(rd_data), 32'h0000_F800);
    check("first_empty",   32'(empty),   32'd0);
    check("first_level",   32'(level),   32'd1);
    check("first_refill",  32'(refill),  32'd1);

    // Fill to full, then a write+pop while full drops the write.
    async_reset("rst_a");
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, WIDTH'(i));
    check("fill_full",  32'(full),  32'd1);
    check("fill_level", 32'(level), 32'(DEPTH));
    step(1'b1, 1'b1, 1'b0, 16'hDEAD);
    check("drop_rd_data", 32'(rd_data), 32'd1);
    check("drop_level",   32'(level),   32'(DEPTH - 1));
`ifdef PIXEL_FIFO_ERR_EN
    check("drop_ovf_cnt",  32'(ovf_cnt),  32'd1);
    check("drop_overflow", 32'(overflow), 32'd1);
`endif

    // Drain across the low-water mark, then pop while empty.
    while (cnt > LOW_WATER) step(1'b0, 1'b1, 1'b0, '0);
    check("lw_level_128",  32'(level),  32'(LOW_WATER));
    check("lw_refill_128", 32'(refill), 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    check("lw_level_127",  32'(level),  32'(LOW_WATER - 1));
    check("lw_refill_127", 32'(refill), 32'd1);
    while (cnt > 0) step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    check("udf_level", 32'(level), 32'd0);
    check("udf_empty", 32'(empty), 32'd1);
`ifdef PIXEL_FIFO_ERR_EN
    check("udf_underflow", 32'(underflow), 32'd1);
    check("udf_cnt",       32'(udf_cnt),   32'd1);
`endif

    // Steady streaming at level 200 across many pointer wraps.
    while (cnt < 200) step(1'b1, 1'b0, 1'b0, WIDTH'($urandom()));
    for (int i = 0; i < 2000; i++) step(1'b1, 1'b1, 1'b0, WIDTH'($urandom()));
    check("stream_level",  32'(level),  32'd200);
    check("stream_refill", 32'(refill), 32'd0);

    // Flush at level 300 with both strobes active.
    while (cnt < 300) step(1'b1, 1'b0, 1'b0, WIDTH'($urandom()));
    step(1'b1, 1'b1, 1'b1, 16'hBEEF);
    check("flush_level",  32'(level),  32'd0);
    check("flush_empty",  32'(empty),  32'd1);
    check("flush_refill", 32'(refill), 32'd1);
`ifdef PIXEL_FIFO_ERR_EN
    check("flush_ovf_cnt", 32'(ovf_cnt), 32'd0);
    check("flush_udf_cnt", 32'(udf_cnt), 32'd0);
`endif
    step(1'b1, 1'b0, 1'b0, 16'h1234);
    check("post_flush_rd_data", 32'(rd_data), 32'h0000_1234);

    // Asynchronous reset in the middle of traffic at level 50.
    while (cnt < 50) step(1'b1, 1'b0, 1'b0, WIDTH'($urandom()));
    async_reset("rst_mid");

    // Random traffic: a fill-biased phase that reaches full, then a
    // drain-biased phase that reaches empty, with rare flushes.
    for (int i = 0; i < 3000; i++) begin
      bit w;
      bit r;
      bit f;
      w = ($urandom_range(99) < ((i < 1500) ? 75 : 35));
      r = ($urandom_range(99) < ((i < 1500) ? 35 : 75));
      f = ($urandom_range(999) < 2);
      step(w, r, f, WIDTH'($urandom()));
    end

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout: simulation did not complete, got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
